// File: rtl/ofdm_sync_frame_ctrl_pkg.sv
// Shared definitions for the ofdm_sync frame scheduler.
//   state_t          : scheduler FSM states
//   SR_* localparams : setting-register addresses used by noc_block_ofdm_sync
//   RB_* localparams : readback addresses for the status counters
package ofdm_sync_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_IN_FRAME = 2'd3
  } state_t;

  localparam int SR_NUM_SYMBOLS  = 129;
  localparam int SR_CTRL_ENABLE  = 130;
  localparam int SR_CTRL_TIMEOUT = 131;

  localparam int RB_FRAME_COUNT   = 0;
  localparam int RB_TIMEOUT_COUNT = 1;
  localparam int RB_SHORT_COUNT   = 2;
  localparam int RB_STATUS        = 3;

endpackage

// File: rtl/ofdm_sync_frame_ctrl_watchdog.sv
// Idle-cycle watchdog for a frame in progress.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : restart the idle count (a beat arrived, or no frame in progress)
//   tick     : one idle cycle inside a frame
//   limit    : idle-cycle limit; 0 disables the watchdog
//   expire   : one-cycle pulse in the idle cycle that reaches the limit
module ofdm_sync_frame_ctrl_watchdog #(
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);

  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt} + (TIMEOUT_W+1)'(1);

  // ">=" rather than "==" so that lowering the limit below an already
  // running count still fires on the next idle cycle instead of wrapping.
  assign expire = tick && !clear && (limit != '0) && (cnt_inc >= {1'b0, limit});

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else if (tick && (limit != '0)) begin
      cnt <= cnt_inc[TIMEOUT_W-1:0];
    end
  end

endmodule

// File: rtl/ofdm_sync_frame_ctrl.sv
// Frame scheduler/configurator for ofdm_sync (ce_clk domain).
// Holds the software-requested symbols/frame in a shadow register and hands it
// to ofdm_sync only between frames. Watches the sync output stream (sof/tlast
// beats) to count symbols and frames, and flushes ofdm_sync when a frame
// stalls mid-stream.
// Ports:
//   ce_clk, ce_rst             : clock, synchronous active-high reset
//   cfg_enable/num_symbols/stb : scheduler enable, requested symbols, write strobe
//   cfg_timeout                : idle-cycle limit inside a frame (0 = off)
//   mon_tvalid/tready/tlast/sof: monitored ofdm_sync output stream
//   sync_num_symbols(_valid)   : value and load pulse towards ofdm_sync
//   sync_flush                 : one-cycle flush pulse towards ofdm_sync
//   frame_done, cfg_err, busy  : status pulses / level
//   frame/timeout/short_count  : saturating readback counters
module ofdm_sync_frame_ctrl
  import ofdm_sync_frame_ctrl_pkg::*;
#(
  parameter  int MAX_NUM_SYMBOLS = 512,
  parameter  int TIMEOUT_W       = 20,
  parameter  int CNT_W           = 16,
  localparam int NSW             = $clog2(MAX_NUM_SYMBOLS + 1)
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic                 cfg_enable,
  input  logic [NSW-1:0]       cfg_num_symbols,
  input  logic                 cfg_stb,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  input  logic                 mon_sof,
  output logic [NSW-1:0]       sync_num_symbols,
  output logic                 sync_num_symbols_valid,
  output logic                 sync_flush,
  output logic                 frame_done,
  output logic                 cfg_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_count,
  output logic [CNT_W-1:0]     timeout_count,
  output logic [CNT_W-1:0]     short_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t         state, next_state;
  logic           beat, cfg_ok, pending;
  logic [NSW-1:0] shadow, active, held, sym_cnt, sym_cnt_next;
  logic           complete, short_ev, wd_expire;

  assign beat   = mon_tvalid & mon_tready;
  assign cfg_ok = cfg_stb && (cfg_num_symbols != '0) &&
                  (cfg_num_symbols <= NSW'(MAX_NUM_SYMBOLS));

  ofdm_sync_frame_ctrl_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk    (ce_clk),
    .rst    (ce_rst),
    .clear  ((state != ST_IN_FRAME) || beat),
    .tick   ((state == ST_IN_FRAME) && !beat),
    .limit  (cfg_timeout),
    .expire (wd_expire)
  );

  // State register
  always_ff @(posedge ce_clk) begin
    if (ce_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state, symbol count and frame events
  always_comb begin
    next_state   = state;
    sym_cnt_next = sym_cnt;
    complete     = 1'b0;
    short_ev     = 1'b0;
    unique case (state)
      ST_IDLE: if (cfg_enable && pending) next_state = ST_ARM;
      ST_ARM:  next_state = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (!cfg_enable)           next_state = ST_IDLE;
        else if (pending)          next_state = ST_ARM;
        else if (beat && mon_sof) begin
          sym_cnt_next = {{(NSW-1){1'b0}}, mon_tlast};
          next_state   = ST_IN_FRAME;
        end
      end
      ST_IN_FRAME: begin
        if (beat) begin
          if (mon_sof) begin
            // New frame started before the previous one completed.
            short_ev     = 1'b1;
            sym_cnt_next = {{(NSW-1){1'b0}}, mon_tlast};
          end else if (mon_tlast) begin
            sym_cnt_next = sym_cnt + NSW'(1);
          end
        end else if (wd_expire) begin
          sym_cnt_next = '0;
          next_state   = cfg_enable ? ST_WAIT_SOF : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // A tlast beat that brings the count up to the armed length closes the
    // frame; this also covers a single-symbol frame seen in WAIT_SOF.
    if ((next_state == ST_IN_FRAME) && beat && mon_tlast && (sym_cnt_next == active)) begin
      complete     = 1'b1;
      sym_cnt_next = '0;
      if (pending && cfg_enable) next_state = ST_ARM;
      else if (cfg_enable)       next_state = ST_WAIT_SOF;
      else                       next_state = ST_IDLE;
    end
  end

  // Outputs; pulses are masked while reset is held so a mid-frame reset
  // never emits a flush or done.
  always_comb begin
    sync_num_symbols_valid = (state == ST_ARM) && !ce_rst;
    sync_num_symbols       = (state == ST_ARM) ? shadow : held;
    sync_flush             = wd_expire && !ce_rst;
    frame_done             = complete && !ce_rst;
    busy                   = (state != ST_IDLE);
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      shadow        <= '0;
      active        <= '0;
      held          <= '0;
      pending       <= 1'b0;
      cfg_err       <= 1'b0;
      sym_cnt       <= '0;
      frame_count   <= '0;
      timeout_count <= '0;
      short_count   <= '0;
    end else begin
      cfg_err <= cfg_stb && !cfg_ok;
      sym_cnt <= sym_cnt_next;
      if (cfg_ok) shadow <= cfg_num_symbols;
      if (state == ST_ARM) begin
        active <= shadow;
        held   <= shadow;
      end
      // A write accepted in the ARM cycle stays pending for the next frame.
      if (cfg_ok)                pending <= 1'b1;
      else if (state == ST_ARM)  pending <= 1'b0;
      if (complete)  frame_count   <= sat_inc(frame_count);
      if (wd_expire) timeout_count <= sat_inc(timeout_count);
      if (short_ev)  short_count   <= sat_inc(short_count);
    end
  end

endmodule
